// File: rtl/calc_pkg.sv
// Shared calculator definitions: 7-segment glyphs (active-low, bit0=a..bit6=g),
// the display driver FSM state type and a small power-of-ten helper.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes go blank.
module seg7_encode
    import calc_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = bcd_to_seg(bcd_i);
    end

endmodule

// File: rtl/display_bcd_driver.sv
// Converts a latched signed-magnitude result to BCD by double-dabble and drives
// a row of 7-segment digits with leading-zero blanking, minus sign and error dash.
module display_bcd_driver
    import calc_pkg::*;
#(
    parameter int VALUE_W = 27,
    parameter int DIGITS  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [VALUE_W-1:0]           value,
    input  logic                         negative,
    input  logic                         error,
    output logic [DIGITS-1:0][6:0]       displays,
    output logic                         busy,
    output logic                         done
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(VALUE_W + 1);
    localparam logic [63:0] MAX_ALL = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] MAX_NEG = pow10(DIGITS - 1) - 64'd1;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     busy_q;
    logic                     done_q;
    logic [DIGITS-1:0][6:0]   disp_q;

    logic [VALUE_W-1:0]       bin_q;
    logic [BCD_W-1:0]         bcd_q;
    logic                     neg_q;
    logic                     dash_q;

    logic [BCD_W-1:0]         bcd_adj;
    logic [DIGITS-1:0][6:0]   seg_w;
    logic [DIGITS-1:0][6:0]   disp_d;
    int                       msd;

    // Double-dabble correction: nibbles >= 5 get +3 before the left shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Operands are captured once at start; out-of-range cases collapse to one dash flag.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && start) begin
            bin_q  <= value;
            bcd_q  <= '0;
            neg_q  <= negative;
            dash_q <= error
                    | (64'(value) > MAX_ALL)
                    | (negative & (64'(value) > MAX_NEG));
        end else if (state_q == SHIFT) begin
            bcd_q <= BCD_W'({bcd_adj, bin_q[VALUE_W-1]});
            bin_q <= {bin_q[VALUE_W-2:0], 1'b0};
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_encode u_seg (
            .bcd_i (bcd_q[4*g +: 4]),
            .seg_o (seg_w[g])
        );
    end

    always_comb begin
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        disp_d = {DIGITS{SEG_BLANK}};
        for (int i = 0; i < DIGITS; i++) begin
            if (dash_q) begin
                disp_d[i] = SEG_DASH;
            end else if (i <= msd) begin
                disp_d[i] = seg_w[i];
            end else if (neg_q && i == msd + 1) begin
                disp_d[i] = SEG_DASH;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= {DIGITS{SEG_BLANK}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                        state_q <= FORMAT;
                    end
                end
                FORMAT: begin
                    disp_q  <= disp_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign displays = disp_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_display_bcd_driver.sv
// Directed bench for display_bcd_driver: conversion latency, formatting, and control corner cases.
module tb_display_bcd_driver;

    localparam int VALUE_W = 27;
    localparam int DIGITS  = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic [VALUE_W-1:0]     value;
    logic                   negative;
    logic                   error;
    logic [DIGITS-1:0][6:0] displays;
    logic                   busy;
    logic                   done;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    display_bcd_driver #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .negative (negative),
        .error    (error),
        .displays (displays),
        .busy     (busy),
        .done     (done)
    );

    // Returns at the falling edge right after the edge that samples start.
    task automatic pulse_start(input logic [VALUE_W-1:0] v, input logic n, input logic e);
        @(negedge clock);
        start    = 1'b1;
        value    = v;
        negative = n;
        error    = e;
        @(negedge clock);
        start    = 1'b0;
        value    = ~v;
        negative = ~n;
        error    = ~e;
    endtask

    task automatic wait_done(input int budget, output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int n = 0; n <= budget; n++) begin
            if (n > 0) @(negedge clock);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock);
            if (done === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset();
        logic [DIGITS-1:0][6:0] exp;
        reset = 1'b1; start = 1'b0; value = '0; negative = 1'b0; error = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        exp = {DIGITS{7'h7F}};
        checks++; if (displays !== exp) begin failures++; $display("FAIL reset_displays got=%h want=%h", displays, exp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    endtask

    task automatic test_convert_124();
        int lat, bc, extra;
        logic [DIGITS-1:0][6:0] exp;
        pulse_start(27'd124, 1'b0, 1'b0);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h7F}};
        exp[0] = 7'h19; exp[1] = 7'h24; exp[2] = 7'h79;
        checks++; if (lat !== 28) begin failures++; $display("FAIL c124_latency got=%0d want=28", lat); end
        checks++; if (displays !== exp) begin failures++; $display("FAIL c124_displays got=%h want=%h", displays, exp); end
        count_done(6, extra);
        checks++; if (extra !== 0) begin failures++; $display("FAIL c124_done_width extra_pulses=%0d want=0", extra); end
        checks++; if (displays !== exp) begin failures++; $display("FAIL c124_hold got=%h want=%h", displays, exp); end
    endtask

    task automatic test_zero();
        int lat, bc;
        logic [DIGITS-1:0][6:0] exp;
        pulse_start(27'd0, 1'b0, 1'b0);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h7F}};
        exp[0] = 7'h40;
        checks++; if (lat !== 28) begin failures++; $display("FAIL zero_latency got=%0d want=28", lat); end
        checks++; if (bc !== 28) begin failures++; $display("FAIL zero_busy_cycles got=%0d want=28", bc); end
        checks++; if (displays !== exp) begin failures++; $display("FAIL zero_displays got=%h want=%h", displays, exp); end
    endtask

    task automatic test_format_cases();
        int lat, bc;
        logic [DIGITS-1:0][6:0] exp;

        pulse_start(27'd35, 1'b1, 1'b0);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h7F}};
        exp[0] = 7'h12; exp[1] = 7'h30; exp[2] = 7'h3F;
        checks++; if (displays !== exp) begin failures++; $display("FAIL neg35 got=%h want=%h", displays, exp); end

        pulse_start(27'd9_999_999, 1'b1, 1'b0);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h10}};
        exp[7] = 7'h3F;
        checks++; if (displays !== exp) begin failures++; $display("FAIL neg_max got=%h want=%h", displays, exp); end

        pulse_start(27'd10_000_000, 1'b1, 1'b0);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h3F}};
        checks++; if (displays !== exp) begin failures++; $display("FAIL neg_over got=%h want=%h", displays, exp); end

        pulse_start(27'd99_999_999, 1'b0, 1'b0);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h10}};
        checks++; if (displays !== exp) begin failures++; $display("FAIL pos_max got=%h want=%h", displays, exp); end

        pulse_start(27'd100_000_000, 1'b0, 1'b0);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h3F}};
        checks++; if (displays !== exp) begin failures++; $display("FAIL pos_over got=%h want=%h", displays, exp); end

        pulse_start(27'd42, 1'b0, 1'b1);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h3F}};
        checks++; if (displays !== exp) begin failures++; $display("FAIL error_dash got=%h want=%h", displays, exp); end
    endtask

    task automatic test_back_to_back();
        int first_done, done_cnt;
        logic [DIGITS-1:0][6:0] exp;
        first_done = -1;
        done_cnt = 0;
        pulse_start(27'd124, 1'b0, 1'b0);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (n == 10) begin start = 1'b1; value = 27'd6; negative = 1'b0; error = 1'b0; end
            if (n == 11) start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
            end
        end
        exp = {DIGITS{7'h7F}};
        exp[0] = 7'h19; exp[1] = 7'h24; exp[2] = 7'h79;
        checks++; if (first_done !== 28) begin failures++; $display("FAIL busy_start_latency got=%0d want=28", first_done); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_start_pulses got=%0d want=1", done_cnt); end
        checks++; if (displays !== exp) begin failures++; $display("FAIL busy_start_displays got=%h want=%h", displays, exp); end
    endtask

    task automatic test_reset_mid_shift();
        int lat, bc, stray;
        logic [DIGITS-1:0][6:0] exp;
        pulse_start(27'd999_999, 1'b0, 1'b0);
        for (int n = 1; n <= 15; n++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp = {DIGITS{7'h7F}};
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", busy); end
        checks++; if (displays !== exp) begin failures++; $display("FAIL midreset_displays got=%h want=%h", displays, exp); end
        count_done(40, stray);
        checks++; if (stray !== 0) begin failures++; $display("FAIL midreset_done pulses=%0d want=0", stray); end

        pulse_start(27'd12, 1'b0, 1'b0);
        wait_done(60, lat, bc);
        exp = {DIGITS{7'h7F}};
        exp[0] = 7'h24; exp[1] = 7'h79;
        checks++; if (lat !== 28) begin failures++; $display("FAIL after_reset_latency got=%0d want=28", lat); end
        checks++; if (displays !== exp) begin failures++; $display("FAIL after_reset_displays got=%h want=%h", displays, exp); end
    endtask

    initial begin
        test_reset();
        test_convert_124();
        test_zero();
        test_format_cases();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
